// File: rtl/unidade_controle_if.sv
// Instruction-source / control-output bundle of the multi-cycle control unit.
// The master side supplies Run and the instruction/immediate word; the slave
// side is the control unit, which drives every datapath control.
interface unidade_controle_if;
    logic       run;
    logic [7:0] din;
    logic [2:0] rx;
    logic [2:0] ry;
    logic       selend;
    logic [1:0] seldado;
    logic       regwr;
    logic       ain;
    logic       gin;
    logic       addsub;
    logic       ocupado;
    logic       done;

    modport master (
        output run, din,
        input  rx, ry, selend, seldado, regwr, ain, gin, addsub, ocupado, done
    );

    modport slave (
        input  run, din,
        output rx, ry, selend, seldado, regwr, ain, gin, addsub, ocupado, done
    );
endinterface

// File: rtl/unidade_controle.sv
// Multi-cycle control unit for the 8-bit datapath. Latches one instruction
// per Run in IDLE and sequences mv/mvi (one cycle) or add/sub (three cycles),
// pulsing Done together with the final register write.
module unidade_controle (
    input  logic                  clk,
    input  logic                  rst,
    unidade_controle_if.slave     bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        T1   = 2'd1,
        T2   = 2'd2,
        T3   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_MV  = 2'b00,
        OP_MVI = 2'b01,
        OP_ADD = 2'b10,
        OP_SUB = 2'b11
    } opcode_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] ir;
    opcode_t    opcode;

    assign opcode = opcode_t'(ir[7:6]);

    // State register; an asynchronous reset aborts any instruction in flight.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Instruction register: loaded only when a Run is accepted in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir <= 8'h00;
        end else if (state == IDLE && bus.run) begin
            ir <= bus.din;
        end
    end

    // Register operands come straight from IR in every state, IDLE included.
    assign bus.rx      = ir[5:3];
    assign bus.ry      = ir[2:0];
    assign bus.ocupado = (state != IDLE);

    // Next-state and control decode from state and IR; Run only steers the
    // next state, so no output depends on it combinationally.
    // NOTE: every signal gets a default before the case so no path through
    // the block leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_next  = state;
        bus.selend  = 1'b0;
        bus.seldado = 2'b00;
        bus.regwr   = 1'b0;
        bus.ain     = 1'b0;
        bus.gin     = 1'b0;
        bus.addsub  = 1'b0;
        bus.done    = 1'b0;

        case (state)
            IDLE: begin
                if (bus.run) begin
                    state_next = T1;
                end
            end
            T1: begin
                case (opcode)
                    OP_MV: begin
                        bus.selend  = 1'b1;
                        bus.seldado = 2'b10;
                        bus.regwr   = 1'b1;
                        bus.done    = 1'b1;
                        state_next  = IDLE;
                    end
                    OP_MVI: begin
                        bus.seldado = 2'b01;
                        bus.regwr   = 1'b1;
                        bus.done    = 1'b1;
                        state_next  = IDLE;
                    end
                    default: begin
                        // add/sub: latch the Rx operand into A.
                        bus.ain    = 1'b1;
                        state_next = T2;
                    end
                endcase
            end
            T2: begin
                // Present Ry and capture A +/- Ry into G; IR[6] selects subtract.
                bus.selend = 1'b1;
                bus.gin    = 1'b1;
                bus.addsub = ir[6];
                state_next = T3;
            end
            T3: begin
                // Write G back into Rx.
                bus.seldado = 2'b00;
                bus.regwr   = 1'b1;
                bus.done    = 1'b1;
                state_next  = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_unidade_controle.sv
// Directed self-checking bench for unidade_controle. Each task drives one
// scenario and compares the packed control vector against hand-computed values.
module tb_unidade_controle;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    unidade_controle_if bus ();

    unidade_controle dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view: {rx, ry, selend, seldado, regwr, ain, gin, addsub, ocupado, done}
    function automatic logic [14:0] ctl();
        return {bus.rx, bus.ry, bus.selend, bus.seldado, bus.regwr,
                bus.ain, bus.gin, bus.addsub, bus.ocupado, bus.done};
    endfunction

    function automatic logic [14:0] mk(input logic [2:0] rx, input logic [2:0] ry,
                                       input logic selend, input logic [1:0] seldado,
                                       input logic regwr, input logic ain, input logic gin,
                                       input logic addsub, input logic ocupado,
                                       input logic done);
        return {rx, ry, selend, seldado, regwr, ain, gin, addsub, ocupado, done};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [14:0] exp;
        rst = 1'b0;
        bus.run = 1'b0;
        bus.din = 8'h00;
        #1 rst = 1'b1;
        #2;
        exp = mk(3'd0, 3'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ctl() !== exp) begin
            $display("FAIL reset_async: got %h expected %h", ctl(), exp);
            errors++;
        end
        tick();
        tick();
        #2 rst = 1'b0;
        tick();
        checks++;
        if (ctl() !== exp) begin
            $display("FAIL reset_idle: got %h expected %h", ctl(), exp);
            errors++;
        end
    endtask

    task automatic test_mv();
        logic [14:0] exp;
        bus.run = 1'b1;
        bus.din = 8'b00_011_101;
        tick();
        bus.run = 1'b0;
        exp = mk(3'd3, 3'd5, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (ctl() !== exp) begin
            $display("FAIL mv_t1: got %h expected %h", ctl(), exp);
            errors++;
        end
        tick();
        exp = mk(3'd3, 3'd5, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ctl() !== exp) begin
            $display("FAIL mv_idle: got %h expected %h", ctl(), exp);
            errors++;
        end
    endtask

    task automatic test_mvi();
        logic [14:0] exp;
        bus.run = 1'b1;
        bus.din = 8'b01_010_000;
        tick();
        bus.run = 1'b0;
        bus.din = 8'hA5;
        exp = mk(3'd2, 3'd0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (ctl() !== exp) begin
            $display("FAIL mvi_t1: got %h expected %h", ctl(), exp);
            errors++;
        end
        tick();
        exp = mk(3'd2, 3'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ctl() !== exp) begin
            $display("FAIL mvi_idle: got %h expected %h", ctl(), exp);
            errors++;
        end
    endtask

    task automatic test_add();
        logic [14:0] exp;
        bus.run = 1'b1;
        bus.din = 8'b10_001_010;
        tick();
        bus.run = 1'b0;
        exp = mk(3'd1, 3'd2, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (ctl() !== exp) begin
            $display("FAIL add_t1: got %h expected %h", ctl(), exp);
            errors++;
        end
        tick();
        exp = mk(3'd1, 3'd2, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        checks++;
        if (ctl() !== exp) begin
            $display("FAIL add_t2: got %h expected %h", ctl(), exp);
            errors++;
        end
        tick();
        exp = mk(3'd1, 3'd2, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (ctl() !== exp) begin
            $display("FAIL add_t3: got %h expected %h", ctl(), exp);
            errors++;
        end
        tick();
        exp = mk(3'd1, 3'd2, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ctl() !== exp) begin
            $display("FAIL add_idle: got %h expected %h", ctl(), exp);
            errors++;
        end
    endtask

    task automatic test_sub_ignore_run();
        logic [14:0] exp;
        bus.run = 1'b1;
        bus.din = 8'b11_111_000;
        tick();
        bus.run = 1'b0;
        exp = mk(3'd7, 3'd0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (ctl() !== exp) begin
            $display("FAIL sub_t1: got %h expected %h", ctl(), exp);
            errors++;
        end
        tick();
        exp = mk(3'd7, 3'd0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if (ctl() !== exp) begin
            $display("FAIL sub_t2: got %h expected %h", ctl(), exp);
            errors++;
        end
        // Run pulse with a zero word while busy must not disturb IR.
        bus.run = 1'b1;
        bus.din = 8'h00;
        tick();
        bus.run = 1'b0;
        exp = mk(3'd7, 3'd0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (ctl() !== exp) begin
            $display("FAIL sub_t3: got %h expected %h", ctl(), exp);
            errors++;
        end
        tick();
        exp = mk(3'd7, 3'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ctl() !== exp) begin
            $display("FAIL sub_idle_ir_kept: got %h expected %h", ctl(), exp);
            errors++;
        end
    endtask

    task automatic test_reset_mid_add();
        logic [14:0] exp;
        bus.run = 1'b1;
        bus.din = 8'b10_110_001;
        tick();
        bus.run = 1'b0;
        tick();
        exp = mk(3'd6, 3'd1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        checks++;
        if (ctl() !== exp) begin
            $display("FAIL rst_mid_t2: got %h expected %h", ctl(), exp);
            errors++;
        end
        #2 rst = 1'b1;
        #1;
        exp = mk(3'd0, 3'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ctl() !== exp) begin
            $display("FAIL rst_mid_zero: got %h expected %h", ctl(), exp);
            errors++;
        end
        tick();
        #2 rst = 1'b0;
        tick();
        checks++;
        if (ctl() !== exp) begin
            $display("FAIL rst_mid_released_idle: got %h expected %h", ctl(), exp);
            errors++;
        end
        // First Run after release is accepted on the next edge.
        bus.run = 1'b1;
        bus.din = 8'b00_100_011;
        tick();
        bus.run = 1'b0;
        exp = mk(3'd4, 3'd3, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (ctl() !== exp) begin
            $display("FAIL rst_first_run: got %h expected %h", ctl(), exp);
            errors++;
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [8:0] done_mask;
        logic [8:0] regwr_mask;
        logic [8:0] ocup_mask;
        done_mask  = '0;
        regwr_mask = '0;
        ocup_mask  = '0;
        bus.run = 1'b1;
        bus.din = 8'b00_011_101;
        for (int c = 1; c <= 8; c++) begin
            tick();
            done_mask[c]  = bus.done;
            regwr_mask[c] = bus.regwr;
            ocup_mask[c]  = bus.ocupado;
            if (c == 1) bus.din = 8'b10_001_010;
            if (c == 5) bus.din = 8'b00_010_110;
            if (c == 7) bus.run = 1'b0;
        end
        // mv done at 1, add done at 5 (4 later), mv done at 7 (2 later).
        checks++;
        if (done_mask !== 9'b010100010) begin
            $display("FAIL b2b_done: got %b expected %b", done_mask, 9'b010100010);
            errors++;
        end
        checks++;
        if (regwr_mask !== 9'b010100010) begin
            $display("FAIL b2b_regwr: got %b expected %b", regwr_mask, 9'b010100010);
            errors++;
        end
        checks++;
        if (ocup_mask !== 9'b010111010) begin
            $display("FAIL b2b_ocupado: got %b expected %b", ocup_mask, 9'b010111010);
            errors++;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_mv();
        test_mvi();
        test_add();
        test_sub_ignore_run();
        test_reset_mid_add();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/unidade_controle.md
# unidade_controle

Multi-cycle control unit for the 8-bit datapath (register file, A/G registers, add/sub ALU, address and data select multiplexers). It accepts one 8-bit instruction per Run request, holds it in an internal instruction register, and sequences the datapath through 1–3 execution cycles. It drives every mux select, register enable and ALU control, then pulses Done. It sits between the instruction source (Din) and the datapath muxes.

## Interface
Parameters: none. Widths are fixed: instruction and data 8 bits, register address 3 bits.

- Clock  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high; returns the block to IDLE.
- Run  input  1  request to start an instruction; sampled only in IDLE.
- Din  input  8  instruction word in IDLE; immediate operand in T1 of mvi.
- Rx  output  3  IR[5:3]; destination register and first operand.
- Ry  output  3  IR[2:0]; second operand.
- SelEnd  output  1  read-address mux select: 0 = Rx, 1 = Ry.
- SelDado  output  2  write-data mux select: 00 = G, 01 = Din, 10 = register read bus, 11 unused (never driven).
- RegWr  output  1  register file write enable; write address is always Rx.
- AIn  output  1  load A from the register read bus.
- GIn  output  1  load G from the ALU output.
- AddSub  output  1  ALU operation: 0 = A + bus, 1 = A − bus.
- Ocupado  output  1  high in any state other than IDLE.
- Done  output  1  one-cycle pulse in the final cycle of each instruction.

## Operation
- Instruction format: IR[7:6] opcode, IR[5:3] Rx, IR[2:0] Ry. Opcodes: 00 mv Rx,Ry; 01 mvi Rx,#Din; 10 add Rx,Ry; 11 sub Rx,Ry.
- States: IDLE, T1, T2, T3. State is registered; all outputs are combinational decodes of state and IR.
- IDLE: all controls are 0. When Run = 1, IR <= Din on the clock edge and the next state is T1. When Run = 0, the block stays in IDLE and IR holds its value.
- T1 for mv: SelEnd = 1, SelDado = 10, RegWr = 1, Done = 1. Next state is IDLE.
- T1 for mvi: SelDado = 01, RegWr = 1, Done = 1. Din must carry the immediate in this cycle. Next state is IDLE.
- T1 for add/sub: SelEnd = 0, AIn = 1. Next state is T2.
- T2 for add/sub: SelEnd = 1, GIn = 1, AddSub = IR[6]. Next state is T3.
- T3 for add/sub: SelDado = 00, RegWr = 1, Done = 1. Next state is IDLE.
- Every control not listed for a state is 0 in that state. SelEnd defaults to 0 and SelDado defaults to 00.
- Run outside IDLE is ignored; it is not queued. Run held high through Done starts the next instruction in the following IDLE cycle.
- Rx/Ry are always driven from IR, including in IDLE.
- Unreachable state encodings return to IDLE on the next clock.

## Timing
- Reset (asynchronous, effective immediately): state = IDLE, IR = 8'h00. Every output is then 0: Rx = 0, Ry = 0, SelEnd = 0, SelDado = 00, RegWr = 0, AIn = 0, GIn = 0, AddSub = 0, Ocupado = 0, Done = 0.
- Reset asserted mid-instruction aborts the instruction with no further RegWr. After Reset deasserts, the first Run is accepted on the next rising edge.
- Latency from the edge that accepts Run to Done: mv and mvi, Done high in the first cycle after acceptance (2 cycles per instruction including IDLE). add and sub, Done high in the third cycle after acceptance (4 cycles per instruction).
- Done and RegWr are asserted together for exactly one cycle per instruction. The register write commits on the Clock edge that ends that cycle.
- Ocupado is high from the cycle after acceptance through the Done cycle inclusive.
- There is no combinational path from Run to any output.

## Test plan
- Reset mid-add: assert Reset while in T2 → all outputs 0 within the same cycle. After release, the state is IDLE and Ocupado = 0.
- mv R3,R5: Run = 1, Din = 8'b00_011_101 → next cycle Rx = 3, Ry = 5, SelEnd = 1, SelDado = 10, RegWr = 1, Done = 1. Following cycle is IDLE.
- mvi R2,#8'hA5: Run with Din = 8'b01_010_000, then Din = 8'hA5 → T1 has SelDado = 01, RegWr = 1, Rx = 2, Done = 1.
- add R1,R2: Din = 8'b10_001_010 → T1 AIn = 1 with SelEnd = 0; T2 GIn = 1, SelEnd = 1, AddSub = 0; T3 SelDado = 00, RegWr = 1, Done = 1.
- sub R7,R0: Din = 8'b11_111_000 → identical sequence with AddSub = 1 in T2. A Run pulse with Din = 8'h00 injected in T2 is ignored and IR is unchanged.
- Back-to-back: Run held high with mv then add words → Done pulses 2 cycles and 4 cycles apart. RegWr never asserts outside the Done cycles.
